// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   SPI mode-0 target that emulates a serial-flash READ (opcode + address, then
//   data out). SCLK/CS/MOSI are oversampled on clk, the command is decoded, and
//   bytes are fetched through a req/ack memory port and shifted out MSB first.
// Ports:
//   clk, reset        system clock (>= 8x data_clk), async active-low reset
//   data_clk          SPI SCLK (idle low)
//   chip_select       SPI CS, active low
//   in_bit / out_bit  MOSI / MISO; out_bit_oe high while selected
//   mem_addr          byte address being fetched
//   mem_rd_req        fetch request, held until mem_rd_ack
//   mem_rd_ack        1-cycle ack, mem_rd_data valid in the same cycle
//   mem_rd_data       fetched byte
//   busy              high from CS fall until return to IDLE
//   cmd_error         1-cycle pulse on an unsupported opcode
//   underrun          1-cycle pulse when a byte starts before its fetch landed
module spi_flash_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_BITS   = 24,
  parameter logic [7:0]  READ_OPCODE = 8'h03
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data_clk,
  input  logic                 chip_select,
  input  logic                 in_bit,
  output logic                 out_bit,
  output logic                 out_bit_oe,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd_req,
  input  logic                 mem_rd_ack,
  input  logic [7:0]           mem_rd_data,
  output logic                 busy,
  output logic                 cmd_error,
  output logic                 underrun
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

  localparam int unsigned CW = $clog2(ADDR_BITS);

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_d, cs_d;
  logic                   cs_fall, cs_rise, sclk_rise, sclk_fall;

  logic [CW-1:0]          bit_cnt;
  logic [ADDR_BITS-2:0]   shift_in;
  logic [7:0]             opcode;
  logic [ADDR_BITS-1:0]   address;
  logic                   last_cmd_bit, last_addr_bit;

  logic [7:0]             prefetch;
  logic                   prefetch_valid;
  logic [6:0]             shift_out;
  logic [2:0]             byte_pos;
  logic                   out_q;
  logic                   ack_taken;

  // CS resynchronizer idles high so a deasserted bus never looks like a CS fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], data_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], chip_select};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], in_bit};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  // Gating with cs_s drops SCLK edges while deselected, including one that
  // coincides with the CS rise.
  assign sclk_rise = ~sclk_d & sclk_s & ~cs_s;
  assign sclk_fall = sclk_d & ~sclk_s & ~cs_s;

  assign opcode        = {shift_in[6:0], mosi_s};
  assign address       = {shift_in, mosi_s};
  assign last_cmd_bit  = (bit_cnt == CW'(7));
  assign last_addr_bit = (bit_cnt == CW'(ADDR_BITS - 1));
  assign ack_taken     = mem_rd_ack & mem_rd_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall) state_d = CMD;
      CMD:     if (sclk_rise && last_cmd_bit)
                 state_d = (opcode == READ_OPCODE) ? ADDR : IGNORE;
      ADDR:    if (sclk_rise && last_addr_bit) state_d = DATA;
      default: state_d = state_q;
    endcase
    if (state_q != IDLE && cs_rise) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt        <= '0;
      shift_in       <= '0;
      mem_addr       <= '0;
      mem_rd_req     <= 1'b0;
      prefetch       <= '0;
      prefetch_valid <= 1'b0;
      shift_out      <= '0;
      byte_pos       <= '0;
      out_q          <= 1'b0;
      cmd_error      <= 1'b0;
      underrun       <= 1'b0;
    end else begin
      cmd_error <= 1'b0;
      underrun  <= 1'b0;
      if (state_q != IDLE && cs_rise) begin
        mem_rd_req     <= 1'b0;
        prefetch_valid <= 1'b0;
        out_q          <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: if (cs_fall) bit_cnt <= '0;
          CMD: if (sclk_rise) begin
            shift_in <= {shift_in[ADDR_BITS-3:0], mosi_s};
            if (last_cmd_bit) begin
              bit_cnt   <= '0;
              cmd_error <= (opcode != READ_OPCODE);
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          ADDR: if (sclk_rise) begin
            shift_in <= {shift_in[ADDR_BITS-3:0], mosi_s};
            bit_cnt  <= bit_cnt + CW'(1);
            if (last_addr_bit) begin
              mem_addr       <= address;
              mem_rd_req     <= 1'b1;
              prefetch_valid <= 1'b0;
              byte_pos       <= '0;
              out_q          <= 1'b0;
            end
          end
          DATA: begin
            if (sclk_fall && byte_pos == 3'd0) begin
              byte_pos <= 3'd1;
              if (prefetch_valid) begin
                shift_out      <= prefetch[6:0];
                out_q          <= prefetch[7];
                prefetch_valid <= 1'b0;
                mem_rd_req     <= 1'b1;
              end else if (ack_taken) begin
                // Fetch lands exactly at byte start: use it directly and keep
                // mem_rd_req high, which now asks for the following address.
                shift_out <= mem_rd_data[6:0];
                out_q     <= mem_rd_data[7];
                mem_addr  <= mem_addr + ADDR_BITS'(1);
              end else begin
                // Request stays outstanding; its data serves the next byte.
                shift_out <= '1;
                out_q     <= 1'b1;
                underrun  <= 1'b1;
              end
            end else begin
              if (sclk_fall) begin
                out_q     <= shift_out[6];
                shift_out <= {shift_out[5:0], 1'b0};
                byte_pos  <= byte_pos + 3'd1;
              end
              if (ack_taken) begin
                prefetch       <= mem_rd_data;
                prefetch_valid <= 1'b1;
                mem_rd_req     <= 1'b0;
                mem_addr       <= mem_addr + ADDR_BITS'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out_bit    = out_q & (state_q == DATA);
  assign out_bit_oe = (state_q != IDLE);
  assign busy       = (state_q != IDLE);

endmodule
